// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with per-key frame debounce, movement vector and new-press event.
// Optional build macro KEYPAD_OPPOSE_CANCEL_EN: opposing stable directions cancel to 0 on mov.
module keypad_scan #(
  parameter int unsigned SCAN_DIV   = 25000,
  parameter int unsigned DEB_FRAMES = 8
) (
  input  logic       sys_clk,
  input  logic       RST_N,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] mov,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned CW = $clog2(DEB_FRAMES) + 1;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_e;

  col_e                  col_q, col_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            rows;
  logic [15:0]           raw_q, raw_d;
  logic                  frame_end_q, frame_end_d;
  logic [15:0]           stable_q, stable_d, stable_prev_q;
  logic [15:0][CW-1:0]   cnt_q, cnt_d;
  logic [15:0]           rise;
  logic [3:0]            mov_q, mov_d;
  logic                  kv_q, kv_d;
  logic [3:0]            code_q, code_d;
  logic                  tick;
  logic [1:0]            col_idx;

  assign rows    = ~sync2_q;
  assign tick    = (presc_q == PW'(SCAN_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);
  assign col_idx = col_q;

  always_comb begin
    col_d   = col_q;
    col_out = '1;
    case (col_q)
      COL0: begin col_out = 4'b1110; if (tick) col_d = COL1; end
      COL1: begin col_out = 4'b1101; if (tick) col_d = COL2; end
      COL2: begin col_out = 4'b1011; if (tick) col_d = COL3; end
      COL3: begin col_out = 4'b0111; if (tick) col_d = COL0; end
      default: col_d = COL0;
    endcase
  end

  always_comb begin
    raw_d       = raw_q;
    frame_end_d = tick && (col_q == COL3);
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        if (tick && (col_idx == 2'(c))) raw_d[r*4 + c] = rows[r];
      end
    end
  end

  // Debounce runs the cycle after the COL3 tick so raw already holds the whole frame.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (frame_end_q) begin
      for (int unsigned k = 0; k < 16; k++) begin
        if (raw_q[k] == stable_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CW'(DEB_FRAMES - 1)) begin
          stable_d[k] = raw_q[k];
          cnt_d[k]    = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end
    end
  end

  assign rise = stable_q & ~stable_prev_q;

  always_comb begin
    kv_d   = |rise;
    code_d = code_q;
    // Scan high-to-low so the lowest set index is the final assignment.
    for (int unsigned i = 0; i < 16; i++) begin
      if (rise[15 - i]) code_d = 4'(15 - i);
    end
    mov_d = {stable_q[1], stable_q[9], stable_q[4], stable_q[6]};
`ifdef KEYPAD_OPPOSE_CANCEL_EN
    if (mov_d[3] && mov_d[2]) mov_d[3:2] = 2'b00;
    if (mov_d[1] && mov_d[0]) mov_d[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      col_q         <= COL0;
      presc_q       <= '0;
      sync1_q       <= '1;
      sync2_q       <= '1;
      raw_q         <= '0;
      frame_end_q   <= 1'b0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      mov_q         <= '0;
      kv_q          <= 1'b0;
      code_q        <= '0;
    end else begin
      col_q         <= col_d;
      presc_q       <= presc_d;
      sync1_q       <= row_in;
      sync2_q       <= sync1_q;
      raw_q         <= raw_d;
      frame_end_q   <= frame_end_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      mov_q         <= mov_d;
      kv_q          <= kv_d;
      code_q        <= code_d;
    end
  end

  assign mov       = mov_q;
  assign key_valid = kv_q;
  assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized self-checking bench for keypad_scan against a frame-level behavioural model.
module tb_keypad_scan;
  localparam int SD = 8;
  localparam int DF = 3;
  localparam int FR = 4 * SD;

  logic       sys_clk = 1'b0;
  logic       RST_N   = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] mov;
  logic       key_valid;
  logic [3:0] key_code;
  logic [15:0] pressed = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_seen  = 0;

  always #5 sys_clk = ~sys_clk;

  // Board: a row reads low when a pressed key sits in the currently driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
  end

  keypad_scan #(.SCAN_DIV(SD), .DEB_FRAMES(DF)) dut (
    .sys_clk  (sys_clk),
    .RST_N    (RST_N),
    .row_in   (row_in),
    .col_out  (col_out),
    .mov      (mov),
    .key_valid(key_valid),
    .key_code (key_code)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mt;
  logic [15:0] hist [4];
  logic [15:0] m_raw, m_stable;
  int          m_cnt [16];
  logic [3:0]  e_mov, e_code;
  logic        e_kv;
  bit          pend;
  int          pend_at;
  logic [15:0] pend_old, pend_new;

  function automatic logic [3:0] mov_of(input logic [15:0] s);
    logic [3:0] m;
    m = {s[1], s[9], s[4], s[6]};
`ifdef KEYPAD_OPPOSE_CANCEL_EN
    if (m[3] && m[2]) m[3:2] = 2'b00;
    if (m[1] && m[0]) m[1:0] = 2'b00;
`endif
    return m;
  endfunction

  always @(posedge sys_clk) begin
    if (!RST_N) begin
      mt = 0; m_raw = '0; m_stable = '0; e_mov = '0; e_code = '0; e_kv = 1'b0; pend = 0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      logic [15:0] snap, old, rise;
      int col;
      hist[mt % 4] = pressed;
      if (mt % SD == SD - 1) begin
        col  = (mt / SD) % 4;
        snap = (mt >= 2) ? hist[(mt - 2) % 4] : 16'h0;
        for (int r = 0; r < 4; r++) m_raw[r*4 + col] = snap[r*4 + col];
      end
      if (mt % FR == FR - 1) begin
        old = m_stable;
        for (int k = 0; k < 16; k++) begin
          if (m_raw[k] == m_stable[k]) m_cnt[k] = 0;
          else if (m_cnt[k] == DF - 1) begin m_stable[k] = m_raw[k]; m_cnt[k] = 0; end
          else m_cnt[k]++;
        end
        pend = 1; pend_at = mt + 3; pend_old = old; pend_new = m_stable;
      end
      mt++;
      e_kv = 1'b0;
      if (pend && mt == pend_at) begin
        e_mov = mov_of(pend_new);
        rise  = pend_new & ~pend_old;
        if (rise != 0) begin
          e_kv = 1'b1;
          for (int i = 15; i >= 0; i--) if (rise[i]) e_code = 4'(i);
        end
        pend = 0;
      end
    end
  end

  always @(negedge sys_clk) begin
    logic [3:0] ec;
    if (!RST_N) begin
      chk("rst_col", {12'h0, col_out}, 16'h000E);
      chk("rst_mov", {12'h0, mov}, 16'h0000);
      chk("rst_kv", {15'h0, key_valid}, 16'h0000);
      chk("rst_code", {12'h0, key_code}, 16'h0000);
    end else begin
      ec = ~(4'b0001 << ((mt / SD) % 4));
      chk("col_out", {12'h0, col_out}, {12'h0, ec});
      chk("mov", {12'h0, mov}, {12'h0, e_mov});
      chk("key_valid", {15'h0, key_valid}, {15'h0, e_kv});
      chk("key_code", {12'h0, key_code}, {12'h0, e_code});
      if (key_valid) kv_seen++;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_t(input int n);
    int g = 0;
    while (mt != n && g < 5000) begin @(negedge sys_clk); g++; end
    if (mt != n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_t: cycle %0d not reached (at %0d)", n, mt);
    end
    #1;
  endtask

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    logic [15:0] pool [8];
    logic [15:0] keep;
    int o, g;
    pool[0] = 16'h0000; pool[1] = 16'h0002; pool[2] = 16'h0010; pool[3] = 16'h0040;
    pool[4] = 16'h0200; pool[5] = 16'h0050; pool[6] = 16'h0202; pool[7] = 16'h0000;

    #1 RST_N = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1 RST_N = 1'b1;

    // Column walk with keys idle
    wait_t(1);  lit("t1_col0", {12'h0, col_out}, 16'h000E); lit("t1_mov", {12'h0, mov}, 16'h0);
    wait_t(8);  lit("t1_col8", {12'h0, col_out}, 16'h000D);
    wait_t(16); lit("t1_col16", {12'h0, col_out}, 16'h000B);
    wait_t(24); lit("t1_col24", {12'h0, col_out}, 16'h0007);
    wait_t(32); lit("t1_col32", {12'h0, col_out}, 16'h000E);

    // Hold '6' from frame start
    pressed = 16'h0040; kv_seen = 0;
    wait_t(129); lit("t2_mov_before", {12'h0, mov}, 16'h0000);
    wait_t(130); lit("t2_mov", {12'h0, mov}, 16'h0001);
    lit("t2_kv", {15'h0, key_valid}, 16'h0001); lit("t2_code", {12'h0, key_code}, 16'h0006);
    wait_t(192); lit("t2_pulses", kv_seen[15:0], 16'h0001);

    // Release '6'
    pressed = 16'h0000; kv_seen = 0;
    wait_t(289); lit("t4_mov_before", {12'h0, mov}, 16'h0001);
    wait_t(290); lit("t4_mov", {12'h0, mov}, 16'h0000); lit("t4_code", {12'h0, key_code}, 16'h0006);

    // Short press of '2'
    wait_t(320); pressed = 16'h0002;
    wait_t(384); pressed = 16'h0000;
    wait_t(480); lit("t34_pulses", kv_seen[15:0], 16'h0000); lit("t3_mov", {12'h0, mov}, 16'h0000);

    // '4' and '6' together
    pressed = 16'h0050; kv_seen = 0;
    wait_t(578); lit("t5_kv", {15'h0, key_valid}, 16'h0001); lit("t5_code", {12'h0, key_code}, 16'h0004);
`ifdef KEYPAD_OPPOSE_CANCEL_EN
    lit("t5_mov", {12'h0, mov}, 16'h0000);
`else
    lit("t5_mov", {12'h0, mov}, 16'h0003);
`endif
    wait_t(600); lit("t5_pulses", kv_seen[15:0], 16'h0001);

    // Reset while '8' is held
    wait_t(608); pressed = 16'h0200;
    wait_t(706); lit("t6_mov_pre", {12'h0, mov}, 16'h0004); lit("t6_code_pre", {12'h0, key_code}, 16'h0009);
    wait_t(720); RST_N = 1'b0; #1;
    lit("t6_rst_mov", {12'h0, mov}, 16'h0000); lit("t6_rst_col", {12'h0, col_out}, 16'h000E);
    repeat (3) @(negedge sys_clk);
    #1 RST_N = 1'b1; kv_seen = 0;
    wait_t(97); lit("t6_mov_before", {12'h0, mov}, 16'h0000);
    wait_t(98); lit("t6_mov", {12'h0, mov}, 16'h0004);
    lit("t6_kv", {15'h0, key_valid}, 16'h0001); lit("t6_code", {12'h0, key_code}, 16'h0009);

    // Random presses with bounce glitches at arbitrary cycle offsets
    for (int seg = 0; seg < 60; seg++) begin
      o = $urandom_range(0, 31);
      repeat (o) @(negedge sys_clk);
      if ($urandom % 2 == 0) begin
        if ($urandom % 8 == 7) pressed = 16'($urandom);
        else pressed = pool[$urandom % 8];
      end
      if ($urandom % 4 == 0) begin
        keep = pressed;
        g = $urandom_range(1, 5);
        pressed = pressed ^ (16'h0001 << $urandom_range(0, 15));
        repeat (g) @(negedge sys_clk);
        pressed = keep;
        o = o + g;
      end
      if (o < 32) repeat (32 - o) @(negedge sys_clk);
    end
    pressed = '0;
    repeat (4 * FR) @(negedge sys_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
